// File: rtl/ac_inverse_gen.sv
// rtl/ac_inverse_gen.sv - scaled inverse of atmospheric light (OMEGA_Q/Ac, Q0.16), one shared restoring divider
// Build option: define AC_INV_ROUND_EN for round-half-up instead of truncating division.
module ac_inverse_gen #(
  parameter logic [15:0] OMEGA_Q = 16'd61440
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  Ac_R,
  input  logic [7:0]  Ac_G,
  input  logic [7:0]  Ac_B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] Ac_Inv_R,
  output logic [15:0] Ac_Inv_G,
  output logic [15:0] Ac_Inv_B
);

  localparam int ITER = 17;

  typedef enum logic [2:0] {IDLE, DIV_R, DIV_G, DIV_B, HOLD} state_t;

  state_t      state_q, state_d;
  logic [4:0]  iter_q, iter_d;
  logic [7:0]  rem_q, rem_d;
  logic [7:0]  div_q, div_d;
  logic [7:0]  ac_g_q, ac_g_d;
  logic [7:0]  ac_b_q, ac_b_d;
  logic [16:0] dq_q, dq_d;
  logic [15:0] inv_r_q, inv_r_d;
  logic [15:0] inv_g_q, inv_g_d;
  logic [15:0] inv_b_q, inv_b_d;
  logic        out_valid_q, out_valid_d;

  logic [8:0]  rem_shift;
  logic        fits;
  logic [16:0] quot;
  logic [15:0] result;
  logic        last;
  logic        dividing;
  logic        load;
  logic [7:0]  next_ac;
  logic [16:0] next_dividend;

  // dq_q shifts dividend bits out at the top while quotient bits enter at the bottom
  assign rem_shift = {rem_q, dq_q[16]};
  assign fits      = rem_shift >= {1'b0, div_q};
  assign quot      = {dq_q[15:0], fits};
  assign result    = (quot[16] || div_q == 8'd0) ? 16'hFFFF : quot[15:0];
  assign last      = iter_q == 5'(ITER - 1);
  assign dividing  = (state_q == DIV_R) || (state_q == DIV_G) || (state_q == DIV_B);

  assign load    = (state_q == IDLE && in_valid) ||
                   (last && (state_q == DIV_R || state_q == DIV_G));
  assign next_ac = (state_q == IDLE)  ? Ac_R :
                   (state_q == DIV_R) ? ac_g_q : ac_b_q;

`ifdef AC_INV_ROUND_EN
  assign next_dividend = {1'b0, OMEGA_Q} + {9'd0, next_ac >> 1};
`else
  assign next_dividend = {1'b0, OMEGA_Q};
`endif

  always_comb begin
    state_d     = state_q;
    iter_d      = iter_q;
    rem_d       = rem_q;
    div_d       = div_q;
    dq_d        = dq_q;
    ac_g_d      = ac_g_q;
    ac_b_d      = ac_b_q;
    inv_r_d     = inv_r_q;
    inv_g_d     = inv_g_q;
    inv_b_d     = inv_b_q;
    out_valid_d = out_valid_q;

    if (dividing) begin
      rem_d  = fits ? 8'(rem_shift - {1'b0, div_q}) : rem_shift[7:0];
      dq_d   = quot;
      iter_d = iter_q + 5'd1;
    end

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          ac_g_d  = Ac_G;
          ac_b_d  = Ac_B;
          state_d = DIV_R;
        end
      end
      DIV_R: begin
        if (last) begin
          inv_r_d = result;
          state_d = DIV_G;
        end
      end
      DIV_G: begin
        if (last) begin
          inv_g_d = result;
          state_d = DIV_B;
        end
      end
      DIV_B: begin
        if (last) begin
          inv_b_d     = result;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Starting a channel overrides the iteration update from the previous channel
    if (load) begin
      rem_d  = 8'd0;
      dq_d   = next_dividend;
      div_d  = next_ac;
      iter_d = 5'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      iter_q      <= 5'd0;
      rem_q       <= 8'd0;
      div_q       <= 8'd0;
      dq_q        <= 17'd0;
      ac_g_q      <= 8'd0;
      ac_b_q      <= 8'd0;
      inv_r_q     <= 16'd0;
      inv_g_q     <= 16'd0;
      inv_b_q     <= 16'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      iter_q      <= iter_d;
      rem_q       <= rem_d;
      div_q       <= div_d;
      dq_q        <= dq_d;
      ac_g_q      <= ac_g_d;
      ac_b_q      <= ac_b_d;
      inv_r_q     <= inv_r_d;
      inv_g_q     <= inv_g_d;
      inv_b_q     <= inv_b_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && rst_n;
  assign out_valid = out_valid_q;
  assign Ac_Inv_R  = inv_r_q;
  assign Ac_Inv_G  = inv_g_q;
  assign Ac_Inv_B  = inv_b_q;

endmodule

// File: tb/tb_ac_inverse_gen.sv
// tb/tb_ac_inverse_gen.sv - self-checking bench for ac_inverse_gen against an arithmetic reference model
module tb_ac_inverse_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [7:0]  ac_r, ac_g, ac_b;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] inv_r, inv_g, inv_b;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int OMEGA = 61440;
`ifdef AC_INV_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  ac_inverse_gen dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .Ac_R(ac_r), .Ac_G(ac_g), .Ac_B(ac_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .Ac_Inv_R(inv_r), .Ac_Inv_G(inv_g), .Ac_Inv_B(inv_b)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_inv(input int ac);
    int dividend;
    int q;
    if (ac == 0) return 16'hFFFF;
    dividend = OMEGA + (ROUND ? ac / 2 : 0);
    q = dividend / ac;
    if (q > 65535) return 16'hFFFF;
    return q[15:0];
  endfunction

  function automatic logic [47:0] ref_job(input int r, input int g, input int b);
    return {ref_inv(r), ref_inv(g), ref_inv(b)};
  endfunction

  // Drives one job, lets it be accepted on the next edge, returns cycles until out_valid (-1 on timeout)
  task automatic send_job(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, output int lat);
    ac_r = r; ac_g = g; ac_b = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 200) lat = -1;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({in_ready, out_valid, inv_r, inv_g, inv_b} !== 50'd0) begin
      n_fail++;
      $display("FAIL reset_during: rdy=%b vld=%b out=%h/%h/%h, want all 0", in_ready, out_valid, inv_r, inv_g, inv_b);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({in_ready, out_valid, inv_r, inv_g, inv_b} !== {2'b10, 48'd0}) begin
      n_fail++;
      $display("FAIL reset_after: rdy=%b vld=%b out=%h/%h/%h, want rdy=1 rest 0", in_ready, out_valid, inv_r, inv_g, inv_b);
    end
  endtask

  task automatic test_basic();
    int lat;
    logic [47:0] spec_val;
    spec_val = ROUND ? {16'd241, 16'd480, 16'd61440} : {16'd240, 16'd480, 16'd61440};
    send_job(8'd255, 8'd128, 8'd1, lat);
    n_checks++;
    if (lat !== 51) begin
      n_fail++; $display("FAIL basic_latency: got %0d, want 51", lat);
    end
    n_checks++;
    if ({inv_r, inv_g, inv_b} !== spec_val) begin
      n_fail++; $display("FAIL basic_values: got %h, want %h", {inv_r, inv_g, inv_b}, spec_val);
    end
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL basic_hold_ready: got %b, want 0", in_ready);
    end
    release_out();
    n_checks++;
    if ({out_valid, in_ready, inv_r, inv_g, inv_b} !== {2'b01, spec_val}) begin
      n_fail++;
      $display("FAIL basic_handshake: vld=%b rdy=%b out=%h, want vld=0 rdy=1 out=%h", out_valid, in_ready, {inv_r, inv_g, inv_b}, spec_val);
    end
  endtask

  task automatic test_round_table();
`ifdef AC_INV_ROUND_EN
    int lat;
    send_job(8'd3, 8'd2, 8'd7, lat);
    n_checks++;
    if ({inv_r, inv_g, inv_b} !== {16'd20480, 16'd30720, 16'd8777} || lat !== 51) begin
      n_fail++; $display("FAIL round_table: got %h lat %0d, want 5000/7800/2249 lat 51", {inv_r, inv_g, inv_b}, lat);
    end
    release_out();
`endif
  endtask

  task automatic test_zero();
    int lat;
    send_job(8'd0, 8'd0, 8'd255, lat);
    n_checks++;
    if (lat !== 51) begin
      n_fail++; $display("FAIL zero_latency: got %0d, want 51", lat);
    end
    n_checks++;
    if ({inv_r, inv_g, inv_b} !== ref_job(0, 0, 255)) begin
      n_fail++; $display("FAIL zero_values: got %h, want %h", {inv_r, inv_g, inv_b}, ref_job(0, 0, 255));
    end
    release_out();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [47:0] exp_v;
    exp_v = ref_job(100, 50, 25);
    send_job(8'd100, 8'd50, 8'd25, lat);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        ac_r = 8'd9; ac_g = 8'd8; ac_b = 8'd7; in_valid = 1'b1;
      end
      if (i == 6) in_valid = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, in_ready, inv_r, inv_g, inv_b} !== {2'b10, exp_v}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: vld=%b rdy=%b out=%h, want 1/0/%h", i, out_valid, in_ready, {inv_r, inv_g, inv_b}, exp_v);
      end
    end
    release_out();
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL bp_release: vld=%b rdy=%b, want 0/1", out_valid, in_ready);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
        n_fail++; $display("FAIL bp_no_queue[%0d]: vld=%b rdy=%b, want 0/1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    ac_r = 8'd50; ac_g = 8'd60; ac_b = 8'd70; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (24) @(posedge clk);
    #1;
    n_checks++;
    if (inv_r !== ref_inv(50)) begin
      n_fail++; $display("FAIL midreset_pre_r: got %h, want %h", inv_r, ref_inv(50));
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, out_valid, inv_r, inv_g, inv_b} !== 50'd0) begin
      n_fail++; $display("FAIL midreset_clear: rdy=%b vld=%b out=%h, want all 0", in_ready, out_valid, {inv_r, inv_g, inv_b});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL midreset_release: rdy=%b vld=%b, want 1/0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    send_job(8'd128, 8'd64, 8'd32, lat);
    n_checks++;
    if ({inv_r, inv_g, inv_b} !== {16'd480, 16'd960, 16'd1920} || lat !== 51) begin
      n_fail++; $display("FAIL midreset_newjob: got %h lat %0d, want 01e0/03c0/0780 lat 51", {inv_r, inv_g, inv_b}, lat);
    end
    release_out();
  endtask

  task automatic test_random();
    int lat;
    int r, g, b;
    for (int n = 0; n < 20; n++) begin
      r = $urandom_range(0, 255); g = $urandom_range(0, 255); b = $urandom_range(0, 255);
      if ($urandom_range(0, 7) == 0) r = 0;
      if ($urandom_range(0, 7) == 0) b = 0;
      send_job(r[7:0], g[7:0], b[7:0], lat);
      n_checks++;
      if ({inv_r, inv_g, inv_b} !== ref_job(r, g, b) || lat !== 51) begin
        n_fail++;
        $display("FAIL random[%0d] ac=%0d/%0d/%0d: got %h lat %0d, want %h lat 51", n, r, g, b, {inv_r, inv_g, inv_b}, lat, ref_job(r, g, b));
      end
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #1;
      release_out();
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    send_job(8'd10, 8'd20, 8'd30, lat);
    n_checks++;
    if ({inv_r, inv_g, inv_b} !== ref_job(10, 20, 30) || lat !== 51) begin
      n_fail++; $display("FAIL b2b_first: got %h lat %0d, want %h lat 51", {inv_r, inv_g, inv_b}, lat, ref_job(10, 20, 30));
    end
    ac_r = 8'd200; ac_g = 8'd100; ac_b = 8'd50;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL b2b_handshake: vld=%b rdy=%b, want 0/1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_accept: rdy=%b, want 0", in_ready);
    end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if ({inv_r, inv_g, inv_b} !== ref_job(200, 100, 50) || lat !== 51) begin
      n_fail++; $display("FAIL b2b_second: got %h lat %0d, want %h lat 51", {inv_r, inv_g, inv_b}, lat, ref_job(200, 100, 50));
    end
    release_out();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ac_r = 8'd0; ac_g = 8'd0; ac_b = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_round_table();
    test_zero();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
